// File: rtl/address_sequencer.sv
// Walks an (i, j) element range for one encoded column and streams one
// (bank, address) beat per data byte to the BRAM read ports.
module address_sequencer #(
    parameter int BRAM_NUMBER_SIZE  = 3,
    parameter int BRAM_ADDRESS_SIZE = 8,
    parameter int I_SIZE            = 1,
    parameter int J_SIZE            = 3,
    parameter int X_SIZE            = 3,
    parameter int DTYPE_BYTES_SIZE  = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         single,
    input  logic [I_SIZE-1:0]            i_first,
    input  logic [J_SIZE-1:0]            j_first,
    input  logic [I_SIZE-1:0]            i_last,
    input  logic [J_SIZE-1:0]            j_last,
    input  logic [X_SIZE-1:0]            x_enc,
    input  logic [BRAM_ADDRESS_SIZE-1:0] base_address,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [BRAM_NUMBER_SIZE-1:0]  bram_number,
    output logic [BRAM_ADDRESS_SIZE-1:0] bram_address,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   state_dbg
);

    // Handshake: a beat moves on a rising edge where out_valid && out_ready;
    // once raised, out_valid and the beat fields hold until that edge.

    localparam int IDX_W = I_SIZE + J_SIZE;
    localparam int SHIFT = IDX_W - BRAM_NUMBER_SIZE + DTYPE_BYTES_SIZE;
    localparam logic [DTYPE_BYTES_SIZE-1:0] B_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic                         one_elem_r;
    logic [J_SIZE-1:0]            j_first_r;
    logic [I_SIZE-1:0]            i_last_r;
    logic [J_SIZE-1:0]            j_last_r;
    logic [X_SIZE-1:0]            x_r;
    logic [BRAM_ADDRESS_SIZE-1:0] base_r;

    logic [I_SIZE-1:0]           i_cnt, i_nxt;
    logic [J_SIZE-1:0]           j_cnt, j_nxt;
    logic [DTYPE_BYTES_SIZE-1:0] b_cnt, b_nxt;

    logic                         xfer;
    logic [IDX_W-1:0]             idx_nxt;
    logic [BRAM_ADDRESS_SIZE-1:0] addr_nxt;
    logic                         beat_last;

    assign state_dbg = state;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Counters point at the beat being presented and step only on a transfer.
    always_comb begin
        state_next = state;
        i_nxt      = i_cnt;
        j_nxt      = j_cnt;
        b_nxt      = b_cnt;
        xfer       = out_valid && out_ready;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (xfer) begin
                    if (out_last) begin
                        state_next = DONE;
                    end else if (b_cnt != B_MAX) begin
                        b_nxt = b_cnt + DTYPE_BYTES_SIZE'(1);
                    end else begin
                        b_nxt = '0;
                        if (j_cnt != j_last_r) begin
                            j_nxt = j_cnt + J_SIZE'(1);
                        end else begin
                            j_nxt = j_first_r;
                            i_nxt = i_cnt + I_SIZE'(1);
                        end
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Truncation to the address width gives the required silent wrap.
        idx_nxt   = {i_nxt, j_nxt};
        addr_nxt  = base_r
                  + (BRAM_ADDRESS_SIZE'(x_r) << SHIFT)
                  + (BRAM_ADDRESS_SIZE'(idx_nxt >> BRAM_NUMBER_SIZE) << DTYPE_BYTES_SIZE)
                  + BRAM_ADDRESS_SIZE'(b_nxt);
        beat_last = (one_elem_r || (i_nxt == i_last_r && j_nxt == j_last_r))
                    && (b_nxt == B_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            one_elem_r   <= 1'b0;
            j_first_r    <= '0;
            i_last_r     <= '0;
            j_last_r     <= '0;
            x_r          <= '0;
            base_r       <= '0;
            i_cnt        <= '0;
            j_cnt        <= '0;
            b_cnt        <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            bram_number  <= '0;
            bram_address <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                // An inverted range collapses to the single first element.
                one_elem_r <= single || (i_first > i_last) || (j_first > j_last);
                j_first_r  <= j_first;
                i_last_r   <= i_last;
                j_last_r   <= j_last;
                x_r        <= x_enc;
                base_r     <= base_address;
                i_cnt      <= i_first;
                j_cnt      <= j_first;
                b_cnt      <= '0;
            end else begin
                i_cnt <= i_nxt;
                j_cnt <= j_nxt;
                b_cnt <= b_nxt;
            end

            busy      <= (state_next == RUN);
            done      <= (state_next == DONE);
            out_valid <= (state == RUN) && (state_next == RUN);
            if (state == RUN && state_next == RUN) begin
                bram_number  <= idx_nxt[BRAM_NUMBER_SIZE-1:0];
                bram_address <= addr_nxt;
                out_last     <= beat_last;
            end else begin
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_address_sequencer.sv
// Randomized scoreboard bench for address_sequencer: a loop-based reference
// model fills the expected queue, a negedge monitor pops and compares beats.
module tb_address_sequencer;

    localparam int BN = 3;
    localparam int BA = 8;
    localparam int IS = 1;
    localparam int JS = 3;
    localparam int XS = 3;
    localparam int DS = 1;
    localparam int BW = BN + BA + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          single;
    logic [IS-1:0] i_first, i_last;
    logic [JS-1:0] j_first, j_last;
    logic [XS-1:0] x_enc;
    logic [BA-1:0] base_address;
    logic          out_ready;
    logic          out_valid;
    logic [BN-1:0] bram_number;
    logic [BA-1:0] bram_address;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    int tests = 0;
    int fails = 0;

    logic [BW-1:0] exp_q[$];
    bit            rnd_ready = 1'b0;
    int            cyc = 0;
    int            xfer_cnt = 0;
    bit            pending_done = 1'b0;
    int            done_cyc = 0;
    bit            prev_stall = 1'b0;
    logic [BW-1:0] prev_beat;

    address_sequencer #(
        .BRAM_NUMBER_SIZE (BN),
        .BRAM_ADDRESS_SIZE(BA),
        .I_SIZE           (IS),
        .J_SIZE           (JS),
        .X_SIZE           (XS),
        .DTYPE_BYTES_SIZE (DS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .single      (single),
        .i_first     (i_first),
        .j_first     (j_first),
        .i_last      (i_last),
        .j_last      (j_last),
        .x_enc       (x_enc),
        .base_address(base_address),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .bram_number (bram_number),
        .bram_address(bram_address),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: enumerate elements with plain nested loops.
    task automatic push_model(input bit sgl, input int i_f, input int j_f,
                              input int i_l, input int j_l, input int x,
                              input int base, output int n);
        int ie, je, idx, bank, addr;
        bit lst;
        n = 0;
        if (sgl || i_f > i_l || j_f > j_l) begin
            ie = i_f;
            je = j_f;
        end else begin
            ie = i_l;
            je = j_l;
        end
        for (int i = i_f; i <= ie; i++)
            for (int j = j_f; j <= je; j++)
                for (int b = 0; b < (1 << DS); b++) begin
                    idx  = i * (1 << JS) + j;
                    bank = idx % (1 << BN);
                    addr = (base + x * (1 << (IS + JS - BN + DS))
                            + (idx / (1 << BN)) * (1 << DS) + b) % (1 << BA);
                    lst  = (i == ie) && (j == je) && (b == (1 << DS) - 1);
                    exp_q.push_back({bank[BN-1:0], addr[BA-1:0], lst});
                    n++;
                end
    endtask

    task automatic scramble_inputs();
        single       = 1'($urandom_range(0, 1));
        i_first      = IS'($urandom);
        i_last       = IS'($urandom);
        j_first      = JS'($urandom);
        j_last       = JS'($urandom);
        x_enc        = XS'($urandom);
        base_address = BA'($urandom);
    endtask

    task automatic drive_cmd(input bit sgl, input int i_f, input int j_f,
                             input int i_l, input int j_l, input int x,
                             input int base, output int n);
        single       = sgl;
        i_first      = IS'(i_f);
        j_first      = JS'(j_f);
        i_last       = IS'(i_l);
        j_last       = JS'(j_l);
        x_enc        = XS'(x);
        base_address = BA'(base);
        start        = 1'b1;
        push_model(sgl, i_f, j_f, i_l, j_l, x, base, n);
    endtask

    // One command end to end; optional starts poked during RUN and DONE.
    task automatic run_cmd(input bit sgl, input int i_f, input int j_f,
                           input int i_l, input int j_l, input int x,
                           input int base, input bit rnd, input bit poke);
        int n, busy_cnt, k;
        bit got_done;
        rnd_ready = rnd;
        drive_cmd(sgl, i_f, j_f, i_l, j_l, x, base, n);
        @(posedge clock); #1;
        start = 1'b0;
        scramble_inputs();
        check("accept_busy_novalid", {busy, out_valid}, 2'b10);
        busy_cnt = busy ? 1 : 0;
        @(posedge clock); #1;
        check("first_beat_latency", out_valid, 1'b1);
        if (busy) busy_cnt++;
        got_done = 1'b0;
        k = 0;
        while (!got_done && k < 5000) begin
            start = (poke && k >= 3 && k <= 6);
            if (start) scramble_inputs();
            @(posedge clock); #1;
            k++;
            if (done) got_done = 1'b1;
            else if (busy) busy_cnt++;
        end
        start = 1'b0;
        check("done_seen", got_done, 1'b1);
        check("queue_drained", exp_q.size(), 0);
        if (!rnd) check("busy_cycles", busy_cnt, n + 1);
        if (poke) begin
            start = 1'b1;
            scramble_inputs();
        end
        @(posedge clock); #1;
        start = 1'b0;
        check("done_pulse_idle", {done, busy, out_valid}, 3'b000);
    endtask

    // ---------------- ready driver ----------------
    always @(posedge clock) begin
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [BW-1:0] beat, exp_beat;
        cyc++;
        beat = {bram_number, bram_address, out_last};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_stable", beat, prev_beat);
            end
            if (pending_done && cyc == done_cyc) begin
                check("done_after_last", {done, busy, out_valid}, 3'b100);
                pending_done = 1'b0;
            end else if (done) begin
                check("unexpected_done", done, 1'b0);
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_valid, 1'b0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", beat, exp_beat);
                    if (exp_beat[0]) begin
                        pending_done = 1'b1;
                        done_cyc = cyc + 1;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = beat;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int n, k;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        single = 1'b0;
        i_first = '0; i_last = '0; j_first = '0; j_last = '0;
        x_enc = '0; base_address = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_values",
              {out_valid, out_last, busy, done, bram_number, bram_address},
              {4'b0000, {BN{1'b0}}, {BA{1'b0}}});
        reset = 1'b0;
        @(posedge clock); #1;

        run_cmd(1, 1, 5, 0, 0, 3, 0, 0, 0);        // single mode
        run_cmd(0, 0, 0, 1, 7, 3, 0, 0, 0);        // full sweep
        run_cmd(0, 0, 0, 1, 7, 3, 0, 1, 0);        // full sweep with stalls
        run_cmd(1, 1, 5, 0, 0, 3, 250, 0, 0);      // address wrap
        run_cmd(0, 1, 2, 0, 6, 3, 0, 0, 0);        // empty i range
        run_cmd(0, 0, 6, 1, 3, 5, 17, 1, 0);       // empty j range
        run_cmd(0, 0, 0, 1, 7, 3, 0, 0, 1);        // starts during RUN/DONE

        // reset mid-sweep after ten beats
        rnd_ready = 1'b0;
        drive_cmd(0, 0, 0, 1, 7, 3, 0, n);
        @(posedge clock); #1;
        start = 1'b0;
        k = xfer_cnt;
        n = 0;
        while (xfer_cnt < k + 10 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("reset_mid_reached_10", (xfer_cnt >= k + 10), 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("reset_mid_outputs", {out_valid, busy, done}, 3'b000);
        exp_q.delete();
        pending_done = 1'b0;
        reset = 1'b0;
        run_cmd(0, 1, 3, 1, 4, 2, 100, 0, 0);      // accepted at next edge

        for (int t = 0; t < 8; t++) begin
            run_cmd(($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/address_sequencer.md
# address_sequencer

Parametrised successor to the combinational BRAM address calculator. On a start command it walks a programmable `(i, j)` element range for one encoded column `x_enc`. For every element it emits a stream of `(bram_number, bram_address)` beats, one per data byte, under a valid/ready handshake. A single-element mode reproduces the legacy one-lookup behaviour. It sits between the sweep control FSM and the BRAM bank read ports.

## Interface
- `BRAM_NUMBER_SIZE`, 3: bank-select width; bank count is 2^BRAM_NUMBER_SIZE.
- `BRAM_ADDRESS_SIZE`, 8: per-bank address width.
- `I_SIZE`, 1: row-index width.
- `J_SIZE`, 3: column-index width. Constraint: I_SIZE+J_SIZE >= BRAM_NUMBER_SIZE.
- `X_SIZE`, 3: encoded-x width.
- `DTYPE_BYTES_SIZE`, 1: log2 of bytes per element; gives 2^DTYPE_BYTES_SIZE beats per element.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: command request, sampled only when idle.
- `single` in 1: 1 = emit only element `(i_first, j_first)`; 0 = full sweep.
- `i_first` in I_SIZE: first i value; in single mode, the i value to emit.
- `j_first` in J_SIZE: first j value; in single mode, the j value to emit.
- `i_last` in I_SIZE: last i value, inclusive.
- `j_last` in J_SIZE: last j value, inclusive.
- `x_enc` in X_SIZE: encoded x for the whole command.
- `base_address` in BRAM_ADDRESS_SIZE: address offset for the command.
- `out_ready` in 1: consumer accepts the current beat.
- `out_valid` out 1: beat present.
- `bram_number` out BRAM_NUMBER_SIZE: target bank.
- `bram_address` out BRAM_ADDRESS_SIZE: address within the bank.
- `out_last` out 1: final beat of the command.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse at command completion.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 at a clock edge latches all command inputs and loads counters: i←i_first, j←j_first, b←0. Next state is RUN.
  - When `start` is accepted, `busy` rises at the same edge.
- Loop order: byte counter `b` innermost (0..2^DTYPE_BYTES_SIZE−1), then `j`, then `i`.
  - j runs j_first..j_last, then reloads to j_first and increments i.
  - The sweep ends after i=i_last, j=j_last, b=max.
- Single mode: only the beats for (i_first, j_first), i.e. 2^DTYPE_BYTES_SIZE beats. `i_last` and `j_last` are ignored.
- Empty-range rule: if i_first>i_last or j_first>j_last (non-single mode), exactly one element (i_first, j_first) is emitted. No wrap-around sweep.
- Per beat, with idx = {i, j} (I_SIZE+J_SIZE bits) and S = I_SIZE+J_SIZE−BRAM_NUMBER_SIZE+DTYPE_BYTES_SIZE:
  - bram_number = idx[BRAM_NUMBER_SIZE−1:0] (low-bit bank interleave).
  - bram_address = base_address + (x_enc << S) + ((idx >> BRAM_NUMBER_SIZE) << DTYPE_BYTES_SIZE) + b.
  - The sum is computed at full width and truncated mod 2^BRAM_ADDRESS_SIZE, so wrap is silent.
- RUN: a beat is transferred when out_valid && out_ready.
  - Counters advance only on a transfer.
  - On the transfer of the `out_last` beat, the FSM moves to DONE.
- DONE: lasts one cycle.
  - `done`=1, `busy`=0, `out_valid`=0.
  - Next state is IDLE.
- `start` is ignored while in RUN or DONE. The command inputs may change freely after acceptance.
- `reset` at any edge forces IDLE and discards any in-flight command. No `done` is produced for it.

## Timing
- Reset values: out_valid=0, out_last=0, busy=0, done=0, bram_number=0, bram_address=0.
- All outputs are registered.
- Latency: `start` sampled at edge N → first beat valid after edge N+1.
- Throughput: one beat per cycle while out_ready=1. No bubbles between elements.
- Backpressure: while out_valid=1 and out_ready=0, bram_number, bram_address and out_last hold stable.
- out_valid never drops without a transfer, except on reset.
- Completion: `out_last` transfer at edge M → done=1 and busy=0 after edge M.
- Earliest next `start` acceptance is at edge M+2, i.e. the first edge in IDLE.
- A `start` asserted during the DONE cycle is ignored.

## Test plan
- Reset then single mode, defaults: x_enc=3, i_first=1, j_first=5, base=0, ready=1.
  - Required: 2 beats, (bank 5, addr 14) then (5, 15, last).
  - done one cycle after the last beat; first beat one cycle after start.
- Full sweep, defaults: i 0..1, j 0..7, x_enc=3, base=0, ready=1.
  - Required: 32 consecutive beats. Banks follow j order 0..7 twice.
  - Addresses 12,13 for i=0 and 14,15 for i=1.
  - Last beat (7, 15, last). busy high for exactly 33 cycles.
- Same sweep with out_ready toggled pseudo-randomly.
  - Required: identical beat sequence; outputs stable during every stall; beat count 32.
- Address wrap: single mode, base=250, x_enc=3, i=1, j=5.
  - Required: addresses 8 and 9 (264 and 265 mod 256).
- Empty range: i_first=1, i_last=0, j_first=2.
  - Required: 2 beats for element (1, 2) only, then done.
- Reset asserted mid-sweep after beat 10.
  - Required next cycle: out_valid=0, busy=0, no done pulse.
  - A new start is accepted at the next edge.
- Start during RUN and during DONE: both ignored, no change to the beat stream.
